// File: rtl/keypad_cmd_encoder_if.sv
// keypad_cmd_encoder_if: keypad matrix lines plus command output bundle
interface keypad_cmd_encoder_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       key_held;
  modport master (input rows, output cols, cmd, cmd_valid, key_held);
  modport slave (output rows, input cols, cmd, cmd_valid, key_held);
endinterface

// File: rtl/keypad_cmd_encoder.sv
// keypad_cmd_encoder: scans a 4x4 keypad, debounces press/release, emits one cmd strobe per key
module keypad_cmd_encoder #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic                     clock,
  input logic                     reset,
  keypad_cmd_encoder_if.master    kp
);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2, RELEASE = 2'd3;
  logic [1:0]     state;
  logic [3:0]     sync1, rows_s, row_pat;
  logic [1:0]     col_idx, row_idx, row_low;
  logic [DW-1:0]  dwell;
  logic [DBW-1:0] dbc;
  logic           one_low;
  assign kp.cols = ~(4'b0001 << col_idx);
  assign one_low = $onehot(~rows_s);
  always_comb row_low = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1        <= 4'hF;
      rows_s       <= 4'hF;
      state        <= SCAN;
      col_idx      <= 2'd0;
      row_idx      <= 2'd0;
      row_pat      <= 4'hF;
      dwell        <= '0;
      dbc          <= '0;
      kp.cmd       <= 4'h0;
      kp.cmd_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      sync1        <= kp.rows;
      rows_s       <= sync1;
      kp.cmd_valid <= 1'b0;
      case (state)
        SCAN: begin
          dwell <= (dwell == DWELL_LAST) ? '0 : dwell + 1'b1;
          if (dwell == DWELL_LAST) begin
            // a press seen on the last dwell cycle keeps the column frozen
            if (one_low) begin
              row_idx <= row_low;
              row_pat <= rows_s;
              dbc     <= '0;
              state   <= DEBOUNCE;
            end else col_idx <= col_idx + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rows_s != row_pat) begin
            col_idx <= col_idx + 1'b1;
            dwell   <= '0;
            state   <= SCAN;
          end else if (dbc == DB_LAST) begin
            kp.cmd       <= {row_idx, col_idx};
            kp.cmd_valid <= 1'b1;
            kp.key_held  <= 1'b1;
            state        <= HELD;
          end else dbc <= dbc + 1'b1;
        end
        HELD: begin
          if (rows_s == 4'hF) begin
            dbc   <= '0;
            state <= RELEASE;
          end
        end
        default: begin
          if (rows_s != 4'hF) state <= HELD;
          else if (dbc == DB_LAST) begin
            kp.key_held <= 1'b0;
            col_idx     <= col_idx + 1'b1;
            dwell       <= '0;
            state       <= SCAN;
          end else dbc <= dbc + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/keypad_cmd_encoder.md
# keypad_cmd_encoder

Upstream input stage for `calc_top`: scans a 4x4 matrix keypad, synchronises and debounces the row returns, and produces the 4-bit `cmd` code consumed by `calc_top`. Each accepted key press yields exactly one `cmd` update plus a one-cycle `cmd_valid` strobe. Keycap legends are arranged so that `{row, col}` equals the calculator command encoding:

- 0–9: digits.
- `4'b1010`: add.
- `4'b1110`: equals.
- Remaining codes: other operators.

## Interface
- `SCAN_DIV`, 16: clock cycles each column is driven during scanning (≥ 4).
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required to accept a press or a release (≥ 2).
- `clock` input 1: single system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rows` input 4: keypad row returns, active-low (external pull-ups), asynchronous to `clock`.
- `cols` output 4: column drive, active-low, exactly one bit low at all times.
- `cmd` output 4: code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`; held until the next accepted key.
- `cmd_valid` output 1: one-cycle strobe, high in the first cycle a new `cmd` is visible.
- `key_held` output 1: high from acceptance until release is debounced.

## Operation
- **Synchroniser.** `rows` passes through a 2-flop synchroniser; all logic uses `rows_s`. A press is valid only when exactly one bit of `rows_s` is 0.
- **Column index.** `col_idx` is a 2-bit index, and `cols = ~(4'b0001 << col_idx)`. It advances 0→1→2→3→0 and wraps.
- **State SCAN.**
  - A dwell counter counts `0..SCAN_DIV-1` per column.
  - On the last dwell cycle:
    - If `rows_s` shows exactly one low bit: latch `row_idx` (position of the low bit) and `row_pat`, clear the debounce counter, go to DEBOUNCE. `col_idx` stays frozen.
    - Otherwise: advance `col_idx`.
  - Multiple low rows are ignored; the column advances.
- **State DEBOUNCE.**
  - Each cycle `rows_s == row_pat`: increment the counter.
  - Any cycle `rows_s != row_pat`: return to SCAN, advance `col_idx`, no output change.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the pattern still matching: on the next edge load `cmd <= {row_idx, col_idx}`, pulse `cmd_valid`, set `key_held`, go to HELD.
- **State HELD.**
  - Columns stay frozen.
  - When `rows_s == 4'hF`: clear the counter, go to RELEASE.
  - Additional keys pressed meanwhile are ignored (no rollover).
- **State RELEASE.**
  - Count consecutive cycles with `rows_s == 4'hF`.
  - Any low bit: back to HELD.
  - When the count reaches `DEBOUNCE_CYCLES-1`: clear `key_held`, advance `col_idx`, go to SCAN.
- **Guarantees.**
  - A held key produces one strobe only; there is no auto-repeat.
  - `cmd` never changes without `cmd_valid`.

## Timing
- **Reset values (asynchronous):**
  - state SCAN, `col_idx` 0, so `cols = 4'b1110`.
  - `cmd = 4'h0`, `cmd_valid = 0`, `key_held = 0`.
  - dwell and debounce counters 0, synchroniser flops `4'hF`.
- **Latency:**
  - Row change to `rows_s`: 2 cycles.
  - DEBOUNCE entry to `cmd_valid` high: exactly `DEBOUNCE_CYCLES` cycles with a stable input.
  - `cmd_valid` width: exactly 1 cycle.
- **Worst-case detect time** (from stable press to DEBOUNCE entry): 2 + 4·`SCAN_DIV` cycles.
- **Release:** `key_held` falls `DEBOUNCE_CYCLES` + 1 cycles after `rows_s` returns to `4'hF`, given stability. `cmd` retains its value.
- **Simultaneous events:**
  - A press detected on the last dwell cycle wins over column advance.
  - A bounce on the exact acceptance cycle aborts acceptance.
- **Reset mid-operation** (any state): immediate return to reset values; a strobe in flight is cancelled. A key still held after reset deasserts is re-detected as a new press.

## Test plan
(`SCAN_DIV` = 4, `DEBOUNCE_CYCLES` = 8; the bench models the keypad by pulling a row low when its column is driven.)
- **Reset:** assert `reset` for 2 cycles, release → `cols = 4'b1110`, `cmd = 0`, `cmd_valid = 0`, `key_held = 0`. `cols` then rotates `1101`, `1011`, `0111`, `1110` every 4 cycles.
- **Clean press of key row 0 / col 1, held 100 cycles, then released:**
  - Exactly one `cmd_valid` pulse with `cmd = 4'd1`.
  - `key_held` is high until 9 cycles after release.
  - Scanning resumes at column 2.
- **Sequence 1, 2, `4'b1010`, 3, `4'b1110`, clean presses each:** five strobes, `cmd` = 1, 2, 10, 3, 14 in order. No extra strobes.
- **Bounce:** key row 3 / col 2 toggles every 3 cycles for 30 cycles, then stays stable → no strobe during toggling; a single strobe with `cmd = 4'd14` after stabilisation. Bounce during release does not produce a second strobe.
- **Two keys:** rows 0 and 1 low in the same column → ignored, no strobe. A second key pressed while the first is held → no strobe, and `cmd` is unchanged.
- **Reset mid-operation:** assert `reset` during DEBOUNCE (counter = 5) → no strobe, outputs at reset values. Key still held after reset deasserts → one strobe after a fresh debounce.
